// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding data-memory responder for an RV32 load/store unit.
//   A request is taken in IDLE, optionally delayed WAIT_CYCLES cycles, then
//   answered in RESP until the requester takes the response.
//   Stores write only their enabled byte lanes.
//   Loads are sign- or zero-extended according to Funct3.
//   The byte-lane logic assumes DWIDTH = 32.
//
// Parameters
//   DWIDTH       data/address width in bits
//   DEPTH_WORDS  storage depth in words (power of two), addresses alias above it
//   WAIT_CYCLES  added access latency, 0..15
//
// Ports
//   Clk_Core, Rst_Core_N      clock (rising edge) and async active-low reset
//   Req_Valid / Req_Ready     request handshake (ready only in IDLE)
//   Req_Write, Req_Addr, Req_Wdata, Req_Funct3   request payload
//   Rsp_Valid / Rsp_Ready     response handshake
//   Rsp_Rdata, Rsp_Err        load data (0 for stores/faults), fault flag
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses fault;
//                          otherwise the low address bits are ignored.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DWIDTH      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [DWIDTH-1:0] Req_Addr,
  input  logic [DWIDTH-1:0] Req_Wdata,
  input  logic [2:0]        Req_Funct3,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DWIDTH-1:0] Rsp_Rdata,
  output logic              Rsp_Err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic       NO_WAIT   = (WAIT_CYCLES == 32'sd0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 32'sd0) ? 4'(WAIT_CYCLES - 32'sd1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Funct3 codes with no RV32 load/store meaning.
  function automatic logic bad_funct3(input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default:                bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte enables: halfwords use lane pair {a[1],0}, so a[0] is ignored.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      3'b000, 3'b100: be = 4'b0001 << lane;
      3'b001, 3'b101: be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data onto every lane it may land in.
  function automatic logic [DWIDTH-1:0] store_data(input logic [2:0] f3, input logic [DWIDTH-1:0] wd);
    logic [DWIDTH-1:0] rep;
    case (f3)
      3'b000, 3'b100: rep = {4{wd[7:0]}};
      3'b001, 3'b101: rep = {2{wd[15:0]}};
      default:        rep = wd;
    endcase
    return rep;
  endfunction

  // Pick the addressed byte/halfword and extend it to a full word.
  function automatic logic [DWIDTH-1:0] load_extend(input logic [DWIDTH-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [2:0] f3);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DWIDTH-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  res = {{(DWIDTH-8){b[7]}}, b};
      3'b100:  res = {{(DWIDTH-8){1'b0}}, b};
      3'b001:  res = {{(DWIDTH-16){h[15]}}, h};
      3'b101:  res = {{(DWIDTH-16){1'b0}}, h};
      3'b010:  res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_idle;
  logic              r_write;
  logic [DWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;
  logic [DWIDTH-1:0] r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic              w_op_write;
  logic [DWIDTH-1:0] w_op_addr;
  logic [DWIDTH-1:0] w_op_wdata;
  logic [2:0]        w_op_funct3;
  logic              w_misalign;
  logic              w_fault;
  logic              w_enter_resp;
  logic              w_commit;
  logic [AW-1:0]     w_idx;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wrep;
  logic [DWIDTH-1:0] w_rword;
  logic [DWIDTH-1:0] w_rsp_data;
  logic              w_unused_addr;

  // Ready is gated by reset so it is low while reset is held and high in the
  // very first cycle after release.
  assign Req_Ready = r_idle & Rst_Core_N;
  assign Rsp_Valid = r_rsp_valid;
  assign Rsp_Rdata = r_rdata;
  assign Rsp_Err   = r_err;

  assign w_accept = Req_Valid & Req_Ready;

  // With no wait states RESP is entered on the accept edge, before the
  // request registers hold the payload, so use the live inputs in IDLE.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_op_write  = Req_Write;
      w_op_addr   = Req_Addr;
      w_op_wdata  = Req_Wdata;
      w_op_funct3 = Req_Funct3;
    end else begin
      w_op_write  = r_write;
      w_op_addr   = r_addr;
      w_op_wdata  = r_wdata;
      w_op_funct3 = r_funct3;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Misaligned halfword/word accesses fault.
  always_comb begin
    case (w_op_funct3)
      3'b001, 3'b101: w_misalign = w_op_addr[0];
      3'b010:         w_misalign = (w_op_addr[1:0] != 2'b00);
      default:        w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_fault      = bad_funct3(w_op_funct3) | w_misalign;
  assign w_enter_resp = ((r_state == S_IDLE) && w_accept && NO_WAIT) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_commit     = w_enter_resp & w_op_write & ~w_fault;
  assign w_idx        = w_op_addr[AW+1:2];
  assign w_be         = store_be(w_op_funct3, w_op_addr[1:0]);
  assign w_wrep       = store_data(w_op_funct3, w_op_wdata);
  assign w_rword      = r_mem[w_idx];

  // Address bits above the storage index alias and are deliberately unused.
  assign w_unused_addr = ^w_op_addr[DWIDTH-1:AW+2];

  // Stores and faults answer with zero data.
  always_comb begin
    if (w_op_write || w_fault) begin
      w_rsp_data = '0;
    end else begin
      w_rsp_data = load_extend(w_rword, w_op_addr[1:0], w_op_funct3);
    end
  end

  // Storage: byte-lane store committed once on the RESP entry edge; never reset.
  always_ff @(posedge Clk_Core) begin
    if (w_commit) begin
      for (int i = 32'sd0; i < 32'sd4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][i*32'sd8 +: 8] <= w_wrep[i*32'sd8 +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_idle      <= 1'b1;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= 3'b000;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= Req_Write;
            r_addr   <= Req_Addr;
            r_wdata  <= Req_Wdata;
            r_funct3 <= Req_Funct3;
            r_idle   <= 1'b0;
            if (NO_WAIT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (Rsp_Ready) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idle      <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
      // Response payload is loaded once on RESP entry and held until taken.
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_err       <= w_fault;
        r_rdata     <= w_rsp_data;
      end
    end
  end

endmodule
